// File: rtl/rtc_bus_pkg.sv
// Shared state encodings and RTC command bytes for the RTC bus
// arbiter and the sequencers that talk through it.
package rtc_bus_pkg;

  typedef enum logic {
    ARB_FREE,
    ARB_OWN
  } arb_state_t;

  typedef enum logic [3:0] {
    TX_IDLE,
    TX_DIRP,
    TX_ALOAD,
    TX_ASET,
    TX_ASTB,
    TX_AHLD,
    TX_DATP,
    TX_DSAMP,
    TX_DSET,
    TX_DSTB,
    TX_DHLD,
    TX_CHG
  } tx_state_t;

  localparam logic [7:0] CMD_CLOCK = 8'hF1;
  localparam logic [7:0] CMD_TIMER = 8'hF2;
  localparam logic [7:0] ADDR_D0   = 8'h24;
  localparam logic [7:0] ADDR_D1   = 8'h25;
  localparam logic [7:0] ADDR_D2   = 8'h26;
  localparam logic [7:0] CMD_DATA  = 8'h01;

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester handshakes plus RTC AD bus and strobes, as seen by
// the arbiter (slave) and by the sequencers/RTC side (master).
interface rtc_bus_arbiter_if;
  import rtc_bus_pkg::*;

  logic       ses_lect;
  logic       ses_esc;
  logic       term_lect;
  logic       term_esc;
  logic       e_lect;
  logic       e_esc;
  logic       tr_lect;
  logic       tr_esc;
  logic [7:0] dir_lect;
  logic [7:0] dir_esc;
  logic       gnt_lect;
  logic       gnt_esc;
  logic       DIR;
  logic       DAT;
  logic       DAT2;
  logic       cambio_estado;
  logic [7:0] Dato_L;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic       err_timeout;

  modport slave (
    input  ses_lect, ses_esc,
    input  term_lect, term_esc,
    input  e_lect, e_esc,
    input  tr_lect, tr_esc,
    input  dir_lect, dir_esc,
    input  ad_in,
    output gnt_lect, gnt_esc,
    output DIR, DAT, DAT2,
    output cambio_estado,
    output Dato_L,
    output ad_out, ad_oe,
    output cs_n, rd_n, wr_n,
    output a_d, err_timeout
  );

  modport master (
    output ses_lect, ses_esc,
    output term_lect, term_esc,
    output e_lect, e_esc,
    output tr_lect, tr_esc,
    output dir_lect, dir_esc,
    output ad_in,
    input  gnt_lect, gnt_esc,
    input  DIR, DAT, DAT2,
    input  cambio_estado,
    input  Dato_L,
    input  ad_out, ad_oe,
    input  cs_n, rd_n, wr_n,
    input  a_d, err_timeout
  );

endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing the setup, strobe and hold phases;
// done is high on the last cycle of the loaded length.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Session arbiter and transaction sequencer for the multiplexed
// RTC AD bus shared by the read and write sequencers.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int T_GAP   = 2,
  parameter int T_PULSE = 8,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               reset,
  rtc_bus_arbiter_if.slave  bus
);

  localparam int PMAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PW-1:0] GAP_L  = PW'(T_GAP - 1);
  localparam logic [PW-1:0] PUL_L  = PW'(T_PULSE - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  arb_state_t arb_q, arb_d;
  tx_state_t  tx_q, tx_d;

  logic          own_esc_q, own_esc_d;
  logic          prio_esc_q, prio_esc_d;
  logic          term_pend_q;
  logic          tr_q;
  logic          chg_q;
  logic          dat2_q;
  logic [TW-1:0] idle_cnt_q;
  logic [7:0]    dato_q;

  logic          ld;
  logic [PW-1:0] ld_val;
  logic          tmr_done;

  logic          ses_o, term_o, e_o, tr_o;
  logic [7:0]    dir_o;
  logic          owned, idle, to_hit, rel;

  logic          cs_n, rd_n, wr_n, a_d, ad_oe;
  logic [7:0]    ad_out;

  assign ses_o  = own_esc_q ? bus.ses_esc  : bus.ses_lect;
  assign term_o = own_esc_q ? bus.term_esc : bus.term_lect;
  assign e_o    = own_esc_q ? bus.e_esc    : bus.e_lect;
  assign tr_o   = own_esc_q ? bus.tr_esc   : bus.tr_lect;
  assign dir_o  = own_esc_q ? bus.dir_esc  : bus.dir_lect;

  assign owned  = (arb_q == ARB_OWN);
  assign idle   = (tx_q == TX_IDLE);
  assign to_hit = owned && idle && !e_o &&
                  (idle_cnt_q == TO_MAX);

  // A term seen mid-transaction only takes effect in CHG.
  assign rel = owned &&
    ((idle && (term_o || !ses_o || to_hit)) ||
     ((tx_q == TX_CHG) && (term_o || term_pend_q)));

  rtc_phase_timer #(.W(PW)) u_tmr (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .val   (ld_val),
    .done  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q      <= ARB_FREE;
      own_esc_q  <= 1'b0;
      prio_esc_q <= 1'b1;
    end else begin
      arb_q      <= arb_d;
      own_esc_q  <= own_esc_d;
      prio_esc_q <= prio_esc_d;
    end
  end

  always_comb begin
    arb_d      = arb_q;
    own_esc_d  = own_esc_q;
    prio_esc_d = prio_esc_q;
    unique case (arb_q)
      ARB_FREE: begin
        if (bus.ses_esc &&
            (prio_esc_q || !bus.ses_lect)) begin
          arb_d      = ARB_OWN;
          own_esc_d  = 1'b1;
          prio_esc_d = 1'b0;
        end else if (bus.ses_lect) begin
          arb_d      = ARB_OWN;
          own_esc_d  = 1'b0;
          prio_esc_d = 1'b1;
        end
      end
      ARB_OWN: begin
        if (rel)
          arb_d = ARB_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      tx_q <= TX_IDLE;
    else
      tx_q <= tx_d;
  end

  always_comb begin
    tx_d   = tx_q;
    ld     = 1'b0;
    ld_val = GAP_L;
    unique case (tx_q)
      TX_IDLE: begin
        if (owned && e_o && !chg_q)
          tx_d = TX_DIRP;
      end
      TX_DIRP:  tx_d = TX_ALOAD;
      TX_ALOAD: begin
        tx_d = TX_ASET;
        ld   = 1'b1;
      end
      TX_ASET: begin
        if (tmr_done) begin
          tx_d   = TX_ASTB;
          ld     = 1'b1;
          ld_val = PUL_L;
        end
      end
      TX_ASTB: begin
        if (tmr_done) begin
          tx_d = TX_AHLD;
          ld   = 1'b1;
        end
      end
      TX_AHLD: begin
        if (tmr_done)
          tx_d = TX_DATP;
      end
      TX_DATP:  tx_d = TX_DSAMP;
      TX_DSAMP: begin
        tx_d = TX_DSET;
        ld   = 1'b1;
      end
      TX_DSET: begin
        if (tmr_done) begin
          tx_d   = TX_DSTB;
          ld     = 1'b1;
          ld_val = PUL_L;
        end
      end
      TX_DSTB: begin
        if (tmr_done) begin
          tx_d = TX_DHLD;
          ld   = 1'b1;
        end
      end
      TX_DHLD: begin
        if (tmr_done)
          tx_d = TX_CHG;
      end
      TX_CHG:  tx_d = TX_IDLE;
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      term_pend_q <= 1'b0;
      tr_q        <= 1'b0;
      chg_q       <= 1'b0;
      dat2_q      <= 1'b0;
      idle_cnt_q  <= '0;
      dato_q      <= '0;
    end else begin
      chg_q  <= (tx_q == TX_CHG);
      dat2_q <= (tx_q == TX_DSTB) && tmr_done && !tr_q;
      if (tx_q == TX_DSAMP)
        tr_q <= tr_o;
      if ((tx_q == TX_DSTB) && tmr_done && !tr_q)
        dato_q <= bus.ad_in;
      if (!owned || (tx_q == TX_CHG))
        term_pend_q <= 1'b0;
      else if (term_o && !idle)
        term_pend_q <= 1'b1;
      if (owned && idle && !e_o) begin
        if (idle_cnt_q != TO_MAX)
          idle_cnt_q <= idle_cnt_q + 1'b1;
      end else begin
        idle_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    a_d    = 1'b0;
    ad_oe  = 1'b0;
    ad_out = '0;
    unique case (tx_q)
      TX_ASET, TX_ASTB: begin
        cs_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = dir_o;
        wr_n   = (tx_q != TX_ASTB);
      end
      TX_AHLD: begin
        ad_oe  = 1'b1;
        ad_out = dir_o;
      end
      TX_DSET, TX_DSTB: begin
        cs_n   = 1'b0;
        a_d    = 1'b1;
        ad_oe  = tr_q;
        ad_out = tr_q ? dir_o : 8'h00;
        if (tx_q == TX_DSTB) begin
          wr_n = !tr_q;
          rd_n = tr_q;
        end
      end
      TX_DHLD: begin
        a_d    = 1'b1;
        ad_oe  = tr_q;
        ad_out = tr_q ? dir_o : 8'h00;
      end
      default: ;
    endcase
  end

  assign bus.cs_n          = cs_n;
  assign bus.rd_n          = rd_n;
  assign bus.wr_n          = wr_n;
  assign bus.a_d           = a_d;
  assign bus.ad_oe         = ad_oe;
  assign bus.ad_out        = ad_out;
  assign bus.gnt_esc       = owned && own_esc_q;
  assign bus.gnt_lect      = owned && !own_esc_q;
  assign bus.DIR           = (tx_q == TX_DIRP);
  assign bus.DAT           = (tx_q == TX_DATP);
  assign bus.DAT2          = dat2_q;
  assign bus.cambio_estado = (tx_q == TX_CHG);
  assign bus.Dato_L        = dato_q;
  assign bus.err_timeout   = to_hit;

endmodule
